// File: rtl/axis_alu_arbiter.sv
// Round-robin arbiter that shares one ALU among several AXI-Stream requesters,
// limits beats in flight, and routes tagged results back to the originating lane.
module axis_alu_arbiter #(
  parameter int REQUESTERS      = 4,
  parameter int OP0_WIDTH       = 16,
  parameter int OP1_WIDTH       = 16,
  parameter int RSLT_WIDTH      = OP0_WIDTH + OP1_WIDTH - 1,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int LOCK_LAST       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS*OP0_WIDTH-1:0]  s_req_tdata_op0,
  input  logic [REQUESTERS*OP1_WIDTH-1:0]  s_req_tdata_op1,
  input  logic [REQUESTERS-1:0]            s_req_tlast,
  input  logic [REQUESTERS-1:0]            s_req_tvalid,
  output logic [REQUESTERS-1:0]            s_req_tready,
  output logic [OP0_WIDTH-1:0]             m_alu_tdata_op0,
  output logic [OP1_WIDTH-1:0]             m_alu_tdata_op1,
  output logic                             m_alu_tlast,
  output logic [ID_WIDTH-1:0]              m_alu_tid,
  output logic                             m_alu_tvalid,
  input  logic                             m_alu_tready,
  input  logic [RSLT_WIDTH-1:0]            s_alu_tdata,
  input  logic                             s_alu_tlast,
  input  logic [ID_WIDTH-1:0]              s_alu_tid,
  input  logic                             s_alu_tvalid,
  output logic                             s_alu_tready,
  output logic [REQUESTERS*RSLT_WIDTH-1:0] m_rsp_tdata,
  output logic [REQUESTERS-1:0]            m_rsp_tlast,
  output logic [REQUESTERS-1:0]            m_rsp_tvalid,
  input  logic [REQUESTERS-1:0]            m_rsp_tready,
  output logic [7:0]                       outstanding,
  output logic                             err_bad_id
);

  localparam int IDX_W = $clog2(REQUESTERS);

  generate
    if (ID_WIDTH < IDX_W) begin : g_bad_id_width
      $error("axis_alu_arbiter: ID_WIDTH too small to encode REQUESTERS");
    end
    if (REQUESTERS < 2 || REQUESTERS > 16) begin : g_bad_requesters
      $error("axis_alu_arbiter: REQUESTERS must be in 2..16");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_outstanding
      $error("axis_alu_arbiter: MAX_OUTSTANDING must be in 1..255");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  gnt, gnt_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [7:0]        outstanding_q;
  logic              room;
  logic              alu_hs;
  logic              rsp_hs;
  logic              tid_ok;
  logic [IDX_W-1:0]  rsp_lane;

  // First valid requester strictly after ptr, wrapping; lowest distance wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0]      ptr,
                                               input logic [REQUESTERS-1:0] vld);
    logic [IDX_W-1:0] pick;
    pick = ptr;
    for (int k = REQUESTERS; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % REQUESTERS;
      if (vld[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  // In-flight count update: simultaneous issue and return cancel, floor at zero.
  function automatic logic [7:0] sat_count(input logic [7:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
    logic [7:0] res;
    res = cnt;
    case ({inc, dec})
      2'b10:   res = (cnt < 8'(MAX_OUTSTANDING)) ? cnt + 8'd1 : cnt;
      2'b01:   res = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

  assign room        = outstanding_q < 8'(MAX_OUTSTANDING);
  assign outstanding = outstanding_q;

  always_comb begin
    s_req_tready = '0;
    m_alu_tvalid = 1'b0;
    if (state == GRANT) begin
      m_alu_tvalid      = s_req_tvalid[gnt] && room;
      s_req_tready[gnt] = m_alu_tready && room;
    end
  end

  assign m_alu_tdata_op0 = s_req_tdata_op0[int'(gnt)*OP0_WIDTH +: OP0_WIDTH];
  assign m_alu_tdata_op1 = s_req_tdata_op1[int'(gnt)*OP1_WIDTH +: OP1_WIDTH];
  assign m_alu_tlast     = s_req_tlast[gnt];
  assign m_alu_tid       = ID_WIDTH'(gnt);
  assign alu_hs          = m_alu_tvalid && m_alu_tready;

  // Extra bit keeps the compare exact when REQUESTERS is a full power of two.
  assign tid_ok   = {1'b0, s_alu_tid} < (ID_WIDTH+1)'(REQUESTERS);
  assign rsp_lane = s_alu_tid[IDX_W-1:0];

  always_comb begin
    m_rsp_tvalid = '0;
    s_alu_tready = 1'b1;
    if (tid_ok) begin
      m_rsp_tvalid[rsp_lane] = s_alu_tvalid;
      s_alu_tready           = m_rsp_tready[rsp_lane];
    end
  end

  assign m_rsp_tdata = {REQUESTERS{s_alu_tdata}};
  assign m_rsp_tlast = {REQUESTERS{s_alu_tlast}};
  assign rsp_hs      = s_alu_tvalid && s_alu_tready;

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (|s_req_tvalid) begin
          gnt_nxt   = rr_pick(rr_ptr, s_req_tvalid);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (alu_hs && (LOCK_LAST == 0 || s_req_tlast[gnt])) begin
          rr_ptr_nxt = gnt;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      rr_ptr        <= IDX_W'(REQUESTERS - 1);
      outstanding_q <= '0;
      err_bad_id    <= 1'b0;
    end else begin
      state         <= state_nxt;
      gnt           <= gnt_nxt;
      rr_ptr        <= rr_ptr_nxt;
      outstanding_q <= sat_count(outstanding_q, alu_hs, rsp_hs);
      // Unknown tags and results nobody is waiting for are both protocol errors.
      if (rsp_hs && (!tid_ok || outstanding_q == 8'd0)) err_bad_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_alu_arbiter.sv
// Directed and randomized bench for axis_alu_arbiter with a round-robin/credit
// reference model and a simple in-bench ALU returning tagged results.
module tb_axis_alu_arbiter;
  localparam int N    = 4;
  localparam int W0   = 8;
  localparam int W1   = 8;
  localparam int RW   = W0 + W1 - 1;
  localparam int IW   = 8;
  localparam int MAXO = 3;

  typedef struct {
    logic [W0-1:0] op0;
    logic [W1-1:0] op1;
    logic          last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] tid;
    logic [RW-1:0] data;
    logic          last;
  } res_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W0-1:0] req_op0;
  logic [N*W1-1:0] req_op1;
  logic [N-1:0]    req_last, req_valid, req_ready;
  logic [W0-1:0]   alu_op0;
  logic [W1-1:0]   alu_op1;
  logic            alu_last, alu_valid, alu_ready;
  logic [IW-1:0]   alu_tid;
  logic [RW-1:0]   res_data;
  logic            res_last, res_valid, res_ready;
  logic [IW-1:0]   res_tid;
  logic [N*RW-1:0] rsp_data;
  logic [N-1:0]    rsp_last, rsp_valid, rsp_ready;
  logic [7:0]      outstanding;
  logic            err_bad_id;

  int checks = 0;
  int errors = 0;

  beat_t         pkt[N][$];
  logic [RW-1:0] exp_rsp[N][$];
  res_t          alu_q[$];
  bit            busy;
  int            cur, last_win, count;

  always #5 clk = ~clk;

  axis_alu_arbiter #(
    .REQUESTERS(N), .OP0_WIDTH(W0), .OP1_WIDTH(W1), .RSLT_WIDTH(RW),
    .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .LOCK_LAST(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_req_tdata_op0(req_op0), .s_req_tdata_op1(req_op1),
    .s_req_tlast(req_last), .s_req_tvalid(req_valid), .s_req_tready(req_ready),
    .m_alu_tdata_op0(alu_op0), .m_alu_tdata_op1(alu_op1), .m_alu_tlast(alu_last),
    .m_alu_tid(alu_tid), .m_alu_tvalid(alu_valid), .m_alu_tready(alu_ready),
    .s_alu_tdata(res_data), .s_alu_tlast(res_last), .s_alu_tid(res_tid),
    .s_alu_tvalid(res_valid), .s_alu_tready(res_ready),
    .m_rsp_tdata(rsp_data), .m_rsp_tlast(rsp_last), .m_rsp_tvalid(rsp_valid),
    .m_rsp_tready(rsp_ready), .outstanding(outstanding), .err_bad_id(err_bad_id)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [W0-1:0] a, input logic [W1-1:0] b,
                         input logic l);
    req_op0[i*W0 +: W0] = a;
    req_op1[i*W1 +: W1] = b;
    req_last[i]         = l;
  endtask

  function automatic logic [RW-1:0] prod(input logic [W0-1:0] a, input logic [W1-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return RW'(p);
  endfunction

  initial begin
    logic [N-1:0] exp_rdy, exp_rv;
    logic         exp_av, exp_rr, room, acc, rsp_hs;
    int           tid;
    beat_t        b;

    req_op0 = '0; req_op1 = '0; req_last = '0; req_valid = '0;
    alu_ready = 1'b1; res_data = '0; res_last = 1'b0; res_tid = '0; res_valid = 1'b0;
    rsp_ready = '1;
    rst = 1'b1;
    repeat (2) tick();

    // Reset state; response demux is purely combinational even in reset
    res_valid = 1'b1; res_tid = 8'd2; res_data = 15'h1234; settle();
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_bad_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_rsp_follow", rsp_valid, 4'b0100);
    res_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Two single-beat requesters from reset: 0 then 2, each after an idle bubble
    set_req(0, 8'h11, 8'h22, 1'b1); set_req(2, 8'h33, 8'h44, 1'b1);
    req_valid = 4'b0101; settle();
    check("bubble0", alu_valid, 0);
    tick(); settle();
    check("g0_tid", alu_tid, 0);
    check("g0_valid", alu_valid, 1);
    check("g0_ready", req_ready, 4'b0001);
    check("g0_op0", alu_op0, 8'h11);
    check("g0_op1", alu_op1, 8'h22);
    tick(); req_valid = 4'b0100; settle();
    check("bubble1", alu_valid, 0);
    check("out_after_g0", outstanding, 1);
    tick(); settle();
    check("g2_tid", alu_tid, 2);
    check("g2_ready", req_ready, 4'b0100);
    check("g2_op0", alu_op0, 8'h33);
    tick(); req_valid = '0; settle();
    check("out_after_g2", outstanding, 2);

    res_valid = 1'b1; res_tid = 8'd0; res_data = 15'h0242; res_last = 1'b1; settle();
    check("rsp0_lanes", rsp_valid, 4'b0001);
    check("rsp0_ready", res_ready, 1);
    check("rsp0_data", rsp_data[0 +: RW], 15'h0242);
    tick(); res_tid = 8'd2; settle();
    check("rsp2_lanes", rsp_valid, 4'b0100);
    check("rsp_last_bcast", rsp_last, 4'b1111);
    tick(); res_valid = 1'b0; res_last = 1'b0; settle();
    check("out_drained", outstanding, 0);

    // Locked 3-beat packet from requester 1 while requester 0 waits
    set_req(1, 8'hA1, 8'h01, 1'b0); req_valid = 4'b0010; settle();
    tick(); set_req(0, 8'h55, 8'h66, 1'b1); req_valid = 4'b0011; settle();
    check("lk_b1_tid", alu_tid, 1);
    check("lk_b1_ready", req_ready, 4'b0010);
    tick(); set_req(1, 8'hA2, 8'h02, 1'b0); settle();
    check("lk_b2_tid", alu_tid, 1);
    check("lk_b2_op0", alu_op0, 8'hA2);
    check("lk_b2_out", outstanding, 1);
    tick(); set_req(1, 8'hA3, 8'h03, 1'b1); settle();
    check("lk_b3_tid", alu_tid, 1);
    check("lk_b3_last", alu_last, 1);
    check("lk_b3_out", outstanding, 2);
    tick(); req_valid = 4'b0001; settle();
    check("lk_idle", alu_valid, 0);
    check("lk_out3", outstanding, 3);

    // Credit limit reached: requester 0 granted but held until a result returns
    tick(); settle();
    check("full_tid", alu_tid, 0);
    check("full_valid", alu_valid, 0);
    check("full_ready", req_ready, 0);
    res_valid = 1'b1; res_tid = 8'd1; res_data = 15'h00A1; settle();
    check("ret1_lane", rsp_valid, 4'b0010);
    tick(); res_valid = 1'b0; settle();
    check("room_out", outstanding, 2);
    check("room_valid", alu_valid, 1);
    check("room_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; settle();
    check("refill_out", outstanding, 3);

    // Response backpressure on lane 1
    res_valid = 1'b1; res_tid = 8'd1; res_data = 15'h0142; rsp_ready = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("hold_ready", res_ready, 0);
      check("hold_lane", rsp_valid, 4'b0010);
      check("hold_data", rsp_data[RW +: RW], 15'h0142);
      check("hold_out", outstanding, 3);
      tick();
    end
    rsp_ready = '1; settle();
    check("rel_ready", res_ready, 1);
    tick(); res_valid = 1'b0; settle();
    check("rel_out", outstanding, 2);

    // Out-of-range tag is swallowed and flagged
    res_valid = 1'b1; res_tid = 8'd7; settle();
    check("bad_ready", res_ready, 1);
    check("bad_lanes", rsp_valid, 0);
    tick(); res_valid = 1'b0; settle();
    check("bad_err", err_bad_id, 1);
    check("bad_out", outstanding, 1);
    repeat (3) tick();
    settle();
    check("bad_sticky", err_bad_id, 1);

    // Asynchronous reset in the middle of a packet with three beats in flight
    set_req(3, 8'h31, 8'h32, 1'b0); req_valid = 4'b1000; settle();
    tick(); settle();
    check("p3_tid", alu_tid, 3);
    tick(); settle();
    check("p3_out2", outstanding, 2);
    tick(); settle();
    check("p3_out3", outstanding, 3);
    check("p3_full", alu_valid, 0);
    rst = 1'b1; settle();
    check("arst_out", outstanding, 0);
    check("arst_err", err_bad_id, 0);
    check("arst_ready", req_ready, 0);
    check("arst_valid", alu_valid, 0);
    tick(); rst = 1'b0;
    alu_ready = 1'b0; set_req(0, 8'h07, 8'h08, 1'b1); req_valid = 4'b1001; settle();
    tick(); settle();
    check("post_rst_tid", alu_tid, 0);
    check("post_rst_valid", alu_valid, 1);

    // Result arriving with nothing in flight
    res_valid = 1'b1; res_tid = 8'd3; res_data = 15'h0077; settle();
    check("orphan_lane", rsp_valid, 4'b1000);
    check("orphan_ready", res_ready, 1);
    tick(); res_valid = 1'b0; settle();
    check("orphan_out", outstanding, 0);
    check("orphan_err", err_bad_id, 1);

    // Randomized traffic against the reference model
    rst = 1'b1; req_valid = '0; alu_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    busy = 1'b0; cur = 0; last_win = N - 1; count = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (pkt[i].size() == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            pkt[i].push_back('{op0: W0'($urandom), op1: W1'($urandom), last: (j == len - 1)});
        end
        set_req(i, pkt[i][0].op0, pkt[i][0].op1, pkt[i][0].last);
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end
      alu_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = N'($urandom);
      res_valid = (alu_q.size() > 0) && ($urandom_range(0, 2) != 0);
      if (alu_q.size() > 0) begin
        res_tid = alu_q[0].tid; res_data = alu_q[0].data; res_last = alu_q[0].last;
      end
      settle();

      room    = (count < MAXO);
      exp_av  = busy && req_valid[cur] && room;
      exp_rdy = (busy && room && alu_ready) ? N'(1 << cur) : '0;
      check("r_alu_valid", alu_valid, exp_av);
      check("r_req_ready", req_ready, exp_rdy);
      check("r_out", outstanding, count);
      check("r_err", err_bad_id, 0);
      if (busy) check("r_tid", alu_tid, cur);
      if (exp_av) begin
        check("r_op0", alu_op0, pkt[cur][0].op0);
        check("r_op1", alu_op1, pkt[cur][0].op1);
        check("r_last", alu_last, pkt[cur][0].last);
      end

      tid    = int'(res_tid);
      exp_rv = res_valid ? N'(1 << tid) : '0;
      exp_rr = rsp_ready[tid];
      check("r_rsp_valid", rsp_valid, exp_rv);
      if (res_valid) check("r_res_ready", res_ready, exp_rr);
      rsp_hs = res_valid && exp_rr;
      if (rsp_hs) begin
        if (exp_rsp[tid].size() == 0) begin
          check("r_rsp_unexpected", 1, 0);
        end else begin
          check("r_rsp_order", rsp_data[tid*RW +: RW], exp_rsp[tid].pop_front());
          check("r_rsp_last", rsp_last[tid], 1);
        end
      end

      if (alu_valid && alu_ready)
        alu_q.push_back('{tid: alu_tid, data: prod(alu_op0, alu_op1), last: 1'b1});
      if (res_valid && res_ready && alu_q.size() > 0) void'(alu_q.pop_front());

      acc = exp_av && alu_ready;
      if (!busy) begin
        if (req_valid != '0) begin
          for (int k = N; k >= 1; k--)
            if (req_valid[(last_win + k) % N]) cur = (last_win + k) % N;
          busy = 1'b1;
        end
      end else if (acc) begin
        b = pkt[cur].pop_front();
        exp_rsp[cur].push_back(prod(b.op0, b.op1));
        if (b.last) begin
          busy     = 1'b0;
          last_win = cur;
        end
      end
      count = count + (acc ? 1 : 0) - (rsp_hs ? 1 : 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
